// File: rtl/ex_branch_resolve_pkg.sv
// Shared constants for the branch execution stage: widths, branch opcodes
// and the bit layout of a queued redirect result.
package ex_branch_resolve_pkg;

   localparam int unsigned dataWidth  = 32;
   localparam int unsigned addrWidth  = 32;
   localparam int unsigned newopWidth = 6;

   localparam logic [newopWidth-1:0] NOP  = 6'd0;
   localparam logic [newopWidth-1:0] BEQ  = 6'd1;
   localparam logic [newopWidth-1:0] BNE  = 6'd2;
   localparam logic [newopWidth-1:0] BLT  = 6'd3;
   localparam logic [newopWidth-1:0] BGE  = 6'd4;
   localparam logic [newopWidth-1:0] BLTU = 6'd5;
   localparam logic [newopWidth-1:0] BGEU = 6'd6;

   // Result entry layout: {taken, next_pc}
   localparam int unsigned RES_TAKEN_BIT = addrWidth;
   localparam int unsigned RES_PC_HI     = addrWidth - 1;
   localparam int unsigned RES_PC_LO     = 0;
   localparam int unsigned RES_W         = addrWidth + 1;

endpackage

// File: rtl/ex_branch_resolve_cond.sv
// Purely combinational branch condition evaluation.
module branch_cond_unit
   import ex_branch_resolve_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 6
) (
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   output logic              taken,
   output logic              bad_op
);

   always_comb begin
      taken  = 1'b0;
      bad_op = 1'b0;
      case (op)
         OP_W'(BEQ):  taken = (src1 == src2);
         OP_W'(BNE):  taken = (src1 != src2);
         OP_W'(BLT):  taken = ($signed(src1) <  $signed(src2));
         OP_W'(BGE):  taken = ($signed(src1) >= $signed(src2));
         OP_W'(BLTU): taken = (src1 <  src2);
         OP_W'(BGEU): taken = (src1 >= src2);
         default:     bad_op = 1'b1;
      endcase
   end

endmodule

// File: rtl/ex_branch_resolve.sv
// Branch execution stage: resolves one conditional branch per cycle and
// queues {taken, next_pc} in a 2-entry FIFO toward the fetch/PC unit.
module ex_branch_resolve
   import ex_branch_resolve_pkg::*;
#(
   parameter int unsigned DATA_W = dataWidth,
   parameter int unsigned ADDR_W = addrWidth,
   parameter int unsigned OP_W   = newopWidth,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              in_en,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [DATA_W-1:0] in_src2,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_offset,
   output logic              redir_valid,
   output logic              redir_taken,
   output logic [ADDR_W-1:0] redir_pc,
   input  logic              redir_ready,
   output logic              full,
   output logic              err_overflow,
   output logic              err_badop
);

   logic              taken;
   logic              bad_op;
   logic [ADDR_W-1:0] next_pc;
   logic [ADDR_W:0]   mem [DEPTH];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic              push;
   logic              pop;
   logic              at_depth;

   branch_cond_unit #(
      .DATA_W (DATA_W),
      .OP_W   (OP_W)
   ) u_cond (
      .op     (in_op),
      .src1   (in_src1),
      .src2   (in_src2),
      .taken  (taken),
      .bad_op (bad_op)
   );

   always_comb begin
      next_pc = taken ? (in_pc + ADDR_W'(in_offset)) : (in_pc + ADDR_W'(4));
   end

   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   always_comb begin
      at_depth = (count == 2'(DEPTH));
      pop      = rdy && (count != 2'd0) && redir_ready;
      push     = rdy && in_en && (!at_depth || pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= '0;
         err_overflow <= 1'b0;
         err_badop    <= 1'b0;
      end else if (rdy) begin
         if (push) begin
            mem[wr_ptr] <= {taken, next_pc};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if (in_en && !push) err_overflow <= 1'b1;
         if (in_en && bad_op) err_badop <= 1'b1;
      end
   end

   always_comb begin
      redir_valid = (count != 2'd0);
      redir_taken = mem[rd_ptr][ADDR_W];
      redir_pc    = mem[rd_ptr][ADDR_W-1:0];
      full        = at_depth;
   end

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Directed bench for ex_branch_resolve with hand-computed expected results.
module tb_ex_branch_resolve;
   import ex_branch_resolve_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        in_en;
   logic [31:0] in_src1;
   logic [31:0] in_src2;
   logic [31:0] in_pc;
   logic [5:0]  in_op;
   logic [31:0] in_offset;
   logic        redir_valid;
   logic        redir_taken;
   logic [31:0] redir_pc;
   logic        redir_ready;
   logic        full;
   logic        err_overflow;
   logic        err_badop;

   int n_tests = 0;
   int n_fail  = 0;

   ex_branch_resolve #(
      .DATA_W (32),
      .ADDR_W (32),
      .OP_W   (6),
      .DEPTH  (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .in_en        (in_en),
      .in_src1      (in_src1),
      .in_src2      (in_src2),
      .in_pc        (in_pc),
      .in_op        (in_op),
      .in_offset    (in_offset),
      .redir_valid  (redir_valid),
      .redir_taken  (redir_taken),
      .redir_pc     (redir_pc),
      .redir_ready  (redir_ready),
      .full         (full),
      .err_overflow (err_overflow),
      .err_badop    (err_badop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] pc, input logic [31:0] off);
      in_en     = 1'b1;
      in_op     = op;
      in_src1   = s1;
      in_src2   = s2;
      in_pc     = pc;
      in_offset = off;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1; in_en = 1'b0; redir_ready = 1'b0;
      in_src1 = '0; in_src2 = '0; in_pc = '0; in_op = NOP; in_offset = '0;
      #2;
      do_reset();
      check("rst_valid", 64'(redir_valid), 64'd0);
      check("rst_taken", 64'(redir_taken), 64'd0);
      check("rst_pc", 64'(redir_pc), 64'd0);
      check("rst_full", 64'(full), 64'd0);
      check("rst_ovf", 64'(err_overflow), 64'd0);
      check("rst_bad", 64'(err_badop), 64'd0);

      // BEQ taken, latency 1, popped next edge
      redir_ready = 1'b1;
      issue(BEQ, 32'd5, 32'd5, 32'h100, 32'h20);
      tick();
      in_en = 1'b0;
      check("beq_valid", 64'(redir_valid), 64'd1);
      check("beq_taken", 64'(redir_taken), 64'd1);
      check("beq_pc", 64'(redir_pc), 64'h120);
      tick();
      check("beq_popped", 64'(redir_valid), 64'd0);

      // Signed vs unsigned compare of the same operands
      issue(BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
      tick();
      check("blt_taken", 64'(redir_taken), 64'd1);
      check("blt_pc", 64'(redir_pc), 64'h240);
      issue(BLTU, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40);
      tick();
      in_en = 1'b0;
      check("bltu_valid", 64'(redir_valid), 64'd1);
      check("bltu_taken", 64'(redir_taken), 64'd0);
      check("bltu_pc", 64'(redir_pc), 64'h304);
      tick();
      check("bltu_popped", 64'(redir_valid), 64'd0);

      // Back-pressure: third issue dropped, first two drain in order
      redir_ready = 1'b0;
      issue(BEQ, 32'd1, 32'd2, 32'h400, 32'h10);
      tick();
      check("bp_full1", 64'(full), 64'd0);
      issue(BNE, 32'd1, 32'd2, 32'h500, 32'h10);
      tick();
      check("bp_full2", 64'(full), 64'd1);
      issue(BGE, 32'd3, 32'd1, 32'h600, 32'h8);
      tick();
      in_en = 1'b0;
      check("bp_ovf", 64'(err_overflow), 64'd1);
      check("bp_head0", {31'd0, redir_taken, redir_pc}, {31'd0, 1'b0, 32'h404});
      redir_ready = 1'b1;
      tick();
      check("bp_head1", {31'd0, redir_taken, redir_pc}, {31'd0, 1'b1, 32'h510});
      check("bp_full3", 64'(full), 64'd0);
      tick();
      check("bp_drained", 64'(redir_valid), 64'd0);

      // Full with simultaneous push and pop
      do_reset();
      redir_ready = 1'b0;
      issue(BGEU, 32'd1, 32'd1, 32'h700, 32'hC);
      tick();
      issue(BGEU, 32'd0, 32'd1, 32'h800, 32'hC);
      tick();
      check("pp_full", 64'(full), 64'd1);
      redir_ready = 1'b1;
      issue(BLTU, 32'd0, 32'd1, 32'h900, 32'h100);
      tick();
      in_en = 1'b0;
      check("pp_no_ovf", 64'(err_overflow), 64'd0);
      check("pp_still_full", 64'(full), 64'd1);
      check("pp_head1", {31'd0, redir_taken, redir_pc}, {31'd0, 1'b0, 32'h804});
      tick();
      check("pp_head2", {31'd0, redir_taken, redir_pc}, {31'd0, 1'b1, 32'hA00});
      tick();
      check("pp_drained", 64'(redir_valid), 64'd0);

      // rdy low freezes everything; reset still works with rdy low
      redir_ready = 1'b0;
      issue(BEQ, 32'd0, 32'd0, 32'h1000, 32'h4);
      tick();
      issue(BNE, 32'd0, 32'd0, 32'h2000, 32'h4);
      tick();
      issue(BEQ, 32'd7, 32'd7, 32'h3000, 32'h4);
      tick();
      check("rdy_pre_ovf", 64'(err_overflow), 64'd1);
      rdy = 1'b0;
      redir_ready = 1'b1;
      issue(NOP, 32'd0, 32'd0, 32'h4000, 32'h4);
      repeat (3) tick();
      check("rdy_valid", 64'(redir_valid), 64'd1);
      check("rdy_head", {31'd0, redir_taken, redir_pc}, {31'd0, 1'b1, 32'h1004});
      check("rdy_full", 64'(full), 64'd1);
      check("rdy_bad", 64'(err_badop), 64'd0);
      in_en = 1'b0;
      do_reset();
      check("rrst_valid", 64'(redir_valid), 64'd0);
      check("rrst_full", 64'(full), 64'd0);
      check("rrst_ovf", 64'(err_overflow), 64'd0);
      check("rrst_pc", 64'(redir_pc), 64'd0);

      // PC wrap and bad opcode
      rdy = 1'b1;
      issue(BNE, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8);
      tick();
      check("wrap_taken", 64'(redir_taken), 64'd1);
      check("wrap_pc", 64'(redir_pc), 64'h4);
      check("wrap_bad", 64'(err_badop), 64'd0);
      issue(NOP, 32'd3, 32'd3, 32'h40, 32'h100);
      tick();
      in_en = 1'b0;
      check("nop_bad", 64'(err_badop), 64'd1);
      check("nop_head", {31'd0, redir_taken, redir_pc}, {31'd0, 1'b0, 32'h44});
      tick();
      check("nop_popped", 64'(redir_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
